// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port, optional R0/bypass,
// a per-register pending scoreboard and a sequential bulk-clear engine.
module reg_file_sb #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              We,
  input  logic [ADDR_W-1:0] Rw,
  input  logic [WIDTH-1:0]  WData,
  input  logic [ADDR_W-1:0] Rs1,
  input  logic [ADDR_W-1:0] Rs2,
  output logic [WIDTH-1:0]  Rd1,
  output logic [WIDTH-1:0]  Rd2,
  input  logic              Lock,
  input  logic [ADDR_W-1:0] LockAddr,
  output logic              Pend1,
  output logic              Pend2,
  input  logic              Clear,
  output logic              Busy,
  output logic              Done
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam logic ZR = (ZERO_REG != 0);
  localparam logic BP = (BYPASS != 0);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [DEPTH-1:0]  pend_q;

  logic busy, wr_acc, lock_acc;
  logic zero1, zero2, hit1, hit2;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (Clear) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end
      end
      S_CLEAR: begin
        // ptr wraps to 0 on the exit cycle, leaving it ready for the next clear
        ptr_d = ptr_q + ADDR_W'(1);
        if (&ptr_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q == S_CLEAR);
  assign Busy     = busy;
  assign Done     = (state_q == S_DONE);

  assign wr_acc   = We   & ~busy & ~(ZR & (Rw == '0));
  assign lock_acc = Lock & ~busy & ~(ZR & (LockAddr == '0));

  assign zero1 = ZR & (Rs1 == '0);
  assign zero2 = ZR & (Rs2 == '0);
  assign hit1  = BP & wr_acc & (Rw == Rs1);
  assign hit2  = BP & wr_acc & (Rw == Rs2);

  assign Rd1   = zero1 ? '0 : (hit1 ? WData : regs_q[Rs1]);
  assign Rd2   = zero2 ? '0 : (hit2 ? WData : regs_q[Rs2]);
  assign Pend1 = ~zero1 & pend_q[Rs1] & ~hit1;
  assign Pend2 = ~zero2 & pend_q[Rs2] & ~hit2;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[ADDR_W'(i)] <= '0;
      pend_q  <= '0;
      state_q <= S_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (busy) begin
        regs_q[ptr_q] <= '0;
        pend_q[ptr_q] <= 1'b0;
      end
      if (wr_acc) begin
        regs_q[Rw] <= WData;
        pend_q[Rw] <= 1'b0;
      end
      // later assignment makes Lock win over a same-address writeback
      if (lock_acc) pend_q[LockAddr] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench: three builds of reg_file_sb (default, no-R0/no-bypass, 32x16)
// driven by shared stimulus and compared each cycle against a behavioural model.
module tb_reg_file_sb;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic        rst, we, lock, clr;
  logic [3:0]  rw, laddr, rs1, rs2;
  logic [31:0] wdata;

  logic [15:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic [31:0] w_rd1, w_rd2;
  logic a_p1, a_p2, a_busy, a_done;
  logic b_p1, b_p2, b_busy, b_done;
  logic w_p1, w_p2, w_busy, w_done;

  reg_file_sb #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) u_a (
    .Clock(Clock), .Reset(rst), .We(we), .Rw(rw[2:0]), .WData(wdata[15:0]),
    .Rs1(rs1[2:0]), .Rs2(rs2[2:0]), .Rd1(a_rd1), .Rd2(a_rd2),
    .Lock(lock), .LockAddr(laddr[2:0]), .Pend1(a_p1), .Pend2(a_p2),
    .Clear(clr), .Busy(a_busy), .Done(a_done));

  reg_file_sb #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) u_b (
    .Clock(Clock), .Reset(rst), .We(we), .Rw(rw[2:0]), .WData(wdata[15:0]),
    .Rs1(rs1[2:0]), .Rs2(rs2[2:0]), .Rd1(b_rd1), .Rd2(b_rd2),
    .Lock(lock), .LockAddr(laddr[2:0]), .Pend1(b_p1), .Pend2(b_p2),
    .Clear(clr), .Busy(b_busy), .Done(b_done));

  reg_file_sb #(.WIDTH(32), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) u_w (
    .Clock(Clock), .Reset(rst), .We(we), .Rw(rw), .WData(wdata),
    .Rs1(rs1), .Rs2(rs2), .Rd1(w_rd1), .Rd2(w_rd2),
    .Lock(lock), .LockAddr(laddr), .Pend1(w_p1), .Pend2(w_p2),
    .Clear(clr), .Busy(w_busy), .Done(w_done));

  logic [31:0] o_rd1 [3], o_rd2 [3], o_p1 [3], o_p2 [3], o_busy [3], o_done [3];
  assign o_rd1[0]  = {16'h0, a_rd1};  assign o_rd2[0]  = {16'h0, a_rd2};
  assign o_rd1[1]  = {16'h0, b_rd1};  assign o_rd2[1]  = {16'h0, b_rd2};
  assign o_rd1[2]  = w_rd1;           assign o_rd2[2]  = w_rd2;
  assign o_p1[0]   = {31'h0, a_p1};   assign o_p2[0]   = {31'h0, a_p2};
  assign o_p1[1]   = {31'h0, b_p1};   assign o_p2[1]   = {31'h0, b_p2};
  assign o_p1[2]   = {31'h0, w_p1};   assign o_p2[2]   = {31'h0, w_p2};
  assign o_busy[0] = {31'h0, a_busy}; assign o_done[0] = {31'h0, a_done};
  assign o_busy[1] = {31'h0, b_busy}; assign o_done[1] = {31'h0, b_done};
  assign o_busy[2] = {31'h0, w_busy}; assign o_done[2] = {31'h0, w_done};

  // Model state: register contents, pending bits, and cycles elapsed since a clear
  // was accepted (0 = not clearing; 1..depth = busy; depth+1 = done pulse).
  logic [31:0] mregs [3][16];
  bit          mpend [3][16];
  int unsigned phase [3];
  int checks = 0;
  int errors = 0;

  function automatic int unsigned amask(int k); return (k == 2) ? 32'hF : 32'h7; endfunction
  function automatic logic [31:0] dmask(int k); return (k == 2) ? 32'hFFFF_FFFF : 32'h0000_FFFF; endfunction
  function automatic int unsigned depth(int k); return (k == 2) ? 16 : 8; endfunction
  function automatic bit zr(int k); return k != 1; endfunction
  function automatic bit bp(int k); return k != 1; endfunction

  function automatic bit busy_m(int k);
    return phase[k] >= 1 && phase[k] <= depth(k);
  endfunction
  function automatic bit wacc_m(int k);
    return we && !busy_m(k) && !(zr(k) && (32'(rw) & amask(k)) == 0);
  endfunction
  function automatic bit lacc_m(int k);
    return lock && !busy_m(k) && !(zr(k) && (32'(laddr) & amask(k)) == 0);
  endfunction
  function automatic bit fwd_m(int k, logic [3:0] rs);
    return bp(k) && wacc_m(k) && ((32'(rw) & amask(k)) == (32'(rs) & amask(k)));
  endfunction

  function automatic logic [31:0] exp_rd(int k, logic [3:0] rs);
    int unsigned a = 32'(rs) & amask(k);
    if (zr(k) && a == 0) return 32'h0;
    if (fwd_m(k, rs))    return wdata & dmask(k);
    return mregs[k][a];
  endfunction
  function automatic logic [31:0] exp_pend(int k, logic [3:0] rs);
    int unsigned a = 32'(rs) & amask(k);
    if (zr(k) && a == 0) return 32'h0;
    return (mpend[k][a] && !fwd_m(k, rs)) ? 32'h1 : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic look();
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rd1[%0d] rs=%0d", k, rs1), o_rd1[k], exp_rd(k, rs1));
      chk($sformatf("rd2[%0d] rs=%0d", k, rs2), o_rd2[k], exp_rd(k, rs2));
      chk($sformatf("pend1[%0d]", k), o_p1[k], exp_pend(k, rs1));
      chk($sformatf("pend2[%0d]", k), o_p2[k], exp_pend(k, rs2));
      chk($sformatf("busy[%0d]", k), o_busy[k], busy_m(k) ? 32'h1 : 32'h0);
      chk($sformatf("done[%0d]", k), o_done[k], (phase[k] == depth(k) + 1) ? 32'h1 : 32'h0);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) begin mregs[k][i] = '0; mpend[k][i] = 1'b0; end
        phase[k] = 0;
      end else begin
        bit bz = busy_m(k);
        bit wa = wacc_m(k);
        bit la = lacc_m(k);
        if (bz) begin
          mregs[k][phase[k] - 1] = '0;
          mpend[k][phase[k] - 1] = 1'b0;
        end
        if (wa) begin
          mregs[k][32'(rw) & amask(k)] = wdata & dmask(k);
          mpend[k][32'(rw) & amask(k)] = 1'b0;
        end
        if (la) mpend[k][32'(laddr) & amask(k)] = 1'b1;
        if (phase[k] == 0)               phase[k] = clr ? 1 : 0;
        else if (phase[k] <= depth(k))   phase[k] = phase[k] + 1;
        else                             phase[k] = 0;
      end
    end
    #1;
  endtask

  task automatic quiet();
    rst = 1'b0; we = 1'b0; lock = 1'b0; clr = 1'b0;
  endtask

  int a_bc, a_dc, w_bc, w_dc;

  initial begin
    quiet();
    rw = '0; laddr = '0; rs1 = '0; rs2 = '0; wdata = '0;
    rst = 1'b1;
    tick();

    // R0 hardwired to zero
    quiet(); we = 1'b1; rw = 4'd0; wdata = 32'h0000_BEEF; rs1 = 4'd0;
    look(); chk("t1_rd1_same", o_rd1[0], 32'h0); chk("t1_pend1", o_p1[0], 32'h0);
    tick();
    we = 1'b0;
    look(); chk("t1_rd1_next", o_rd1[0], 32'h0);
    tick();

    // write-to-read bypass vs. no bypass
    we = 1'b1; rw = 4'd3; wdata = 32'h0000_1234; rs1 = 4'd3;
    look(); chk("t2_bypass", o_rd1[0], 32'h1234); chk("t2_nobypass_old", o_rd1[1], 32'h0);
    tick();
    we = 1'b0;
    look(); chk("t2_nobypass_new", o_rd1[1], 32'h1234);
    tick();

    // scoreboard lock / writeback / lock-wins
    lock = 1'b1; laddr = 4'd5;
    look(); tick();
    lock = 1'b0; rs2 = 4'd5;
    look(); chk("t3_pend_set", o_p2[0], 32'h1);
    tick();
    we = 1'b1; rw = 4'd5; wdata = 32'h0000_00A5;
    look(); chk("t3_pend_fwd", o_p2[0], 32'h0); chk("t3_rd_fwd", o_rd2[0], 32'h00A5);
    tick();
    we = 1'b1; lock = 1'b1; laddr = 4'd5; rw = 4'd5; wdata = 32'h0000_5A5A;
    look(); chk("t3_rd_lockwr", o_rd2[0], 32'h5A5A);
    tick();
    quiet();
    look(); chk("t3_lock_wins", o_p2[0], 32'h1); chk("t3_data_kept", o_rd2[0], 32'h5A5A);
    tick();

    // bulk clear: busy length, done pulse, writes dropped while busy
    for (int i = 1; i < 16; i++) begin
      we = 1'b1; rw = 4'(i); wdata = 32'hFFFF_FFFF;
      look(); tick();
    end
    quiet(); clr = 1'b1;
    look(); tick();
    clr = 1'b0;
    a_bc = 0; a_dc = 0; w_bc = 0; w_dc = 0;
    for (int n = 0; n < 22; n++) begin
      we = (n < 4); rw = 4'd2; wdata = 32'hFFFF_FFFF;
      look();
      a_bc += int'(a_busy); a_dc += int'(a_done);
      w_bc += int'(w_busy); w_dc += int'(w_done);
      tick();
    end
    quiet();
    chk("t4_a_busy_cycles", 32'(a_bc), 32'd8);
    chk("t4_a_done_pulses", 32'(a_dc), 32'd1);
    chk("t4_w_busy_cycles", 32'(w_bc), 32'd16);
    chk("t4_w_done_pulses", 32'(w_dc), 32'd1);
    for (int i = 0; i < 16; i++) begin
      rs1 = 4'(i); rs2 = 4'(15 - i);
      look(); chk("t4_a_cleared", o_rd1[0], 32'h0); chk("t4_w_cleared", o_rd1[2], 32'h0);
      tick();
    end

    // reset three cycles into a clear
    for (int i = 1; i < 8; i++) begin
      we = 1'b1; rw = 4'(i); wdata = 32'h1111_1111;
      look(); tick();
    end
    quiet(); clr = 1'b1;
    look(); tick();
    clr = 1'b0;
    for (int n = 0; n < 2; n++) begin look(); tick(); end
    rst = 1'b1;
    look(); tick();
    rst = 1'b0;
    a_dc = 0;
    for (int i = 0; i < 12; i++) begin
      rs1 = 4'(i); rs2 = 4'(i + 1);
      look();
      if (i == 0) chk("t5_busy_dropped", o_busy[0], 32'h0);
      a_dc += int'(a_done);
      chk("t5_regs_zero", o_rd1[0], 32'h0);
      tick();
    end
    chk("t5_no_done", 32'(a_dc), 32'd0);

    // randomized traffic against the model
    for (int it = 0; it < 1000; it++) begin
      rst   = ($urandom_range(0, 199) == 0);
      we    = 1'($urandom_range(0, 1));
      lock  = ($urandom_range(0, 3) == 0);
      clr   = ($urandom_range(0, 59) == 0);
      rw    = 4'($urandom_range(0, 15));
      laddr = ($urandom_range(0, 3) == 0) ? rw : 4'($urandom_range(0, 15));
      rs1   = ($urandom_range(0, 2) == 0) ? rw : 4'($urandom_range(0, 15));
      rs2   = 4'($urandom_range(0, 15));
      wdata = $urandom;
      look(); tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
